sd_spi_responder: RTL

//  SPI-mode SD card responder (card side). Drives the SPI bus opposite the SD host controller.

---
 rtl/sd_spi_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model (card side): decodes 6-byte commands and serves single-block
// reads/writes from a byte-wide backing memory. The system clock must run at least 8x SCLK.
module sd_spi_responder #(
  parameter int unsigned ADDR_W     = 18,  // must be at least 18 (9 block bits + 9 byte bits)
  parameter int unsigned INIT_POLLS = 2,
  parameter int unsigned NCR        = 1,
  parameter int unsigned READ_GAP   = 2,
  parameter int unsigned BUSY_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SPI_CS,
  input  logic              SPI_SCLK,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              card_ready,
  output logic              cmd_valid,
  output logic [5:0]        cmd_index
);

  localparam int unsigned BLK_W = ADDR_W - 9;

  typedef enum logic [3:0] {
    StWaitCmd, StCmdBytes, StNcrGap, StResp, StRdGap, StRdData,
    StWrToken, StWrData, StWrCrc, StWrResp, StBusy
  } state_e;

  typedef enum logic [1:0] {AfterNone, AfterRead, AfterWrite} after_e;

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_prev;
  logic       cs_low, sclk_rise, sclk_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], SPI_CS};
      sclk_sync <= {sclk_sync[0], SPI_SCLK};
      mosi_sync <= {mosi_sync[0], SPI_MOSI};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_low    = ~cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;

  // Byte layer: shift in on rise, shift out on fall; the fall after the 8th rise loads tx_next.
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, tx_next, rx_byte;
  logic       byte_done;

  assign byte_done = cs_low & sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_sync[1]};
  assign SPI_MISO  = tx_shift[7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'hFF;
    end else if (!cs_low) begin
      bit_cnt  <= 3'd0;
      tx_shift <= 8'hFF;
    end else begin
      if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[5:0], mosi_sync[1]};
      end
      if (sclk_fall) begin
        tx_shift <= (bit_cnt == 3'd0) ? tx_next : {tx_shift[6:0], 1'b1};
      end
    end
  end

  state_e            state_q, state_d;
  after_e            after_q, after_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [5:0]        cmd_idx_q, cmd_idx_d;
  logic [BLK_W-1:0]  arg_q, arg_d;
  logic [39:0]       resp_q, resp_d;
  logic [2:0]        resp_len_q, resp_len_d;
  logic              app_q, app_d;
  logic [7:0]        polls_q, polls_d;
  logic              card_ready_q, card_ready_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [5:0]        cmd_index_q, cmd_index_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        r1;
  logic              idle;

  assign idle = ~card_ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StWaitCmd;
      after_q      <= AfterNone;
      cnt_q        <= '0;
      cmd_idx_q    <= '0;
      arg_q        <= '0;
      resp_q       <= '1;
      resp_len_q   <= 3'd1;
      app_q        <= 1'b0;
      polls_q      <= '0;
      card_ready_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      after_q      <= after_d;
      cnt_q        <= cnt_d;
      cmd_idx_q    <= cmd_idx_d;
      arg_q        <= arg_d;
      resp_q       <= resp_d;
      resp_len_q   <= resp_len_d;
      app_q        <= app_d;
      polls_q      <= polls_d;
      card_ready_q <= card_ready_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    after_d      = after_q;
    cnt_d        = cnt_q;
    cmd_idx_d    = cmd_idx_q;
    arg_d        = arg_q;
    resp_d       = resp_q;
    resp_len_d   = resp_len_q;
    app_d        = app_q;
    polls_d      = polls_q;
    card_ready_d = card_ready_q;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    tx_next      = 8'hFF;
    r1           = 8'h00;

    case (state_q)
      StWaitCmd: begin
        if (byte_done && rx_byte[7:6] == 2'b01) begin
          cmd_idx_d = rx_byte[5:0];
          cnt_d     = '0;
          state_d   = StCmdBytes;
        end
      end
      StCmdBytes: begin
        if (byte_done) begin
          if (cnt_q < 10'd4) begin
            // Only the low argument bits are kept: block number and CMD8 echo byte.
            arg_d = {arg_q[BLK_W-9:0], rx_byte};
            cnt_d = cnt_q + 10'd1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_index_d = cmd_idx_q;
            app_d       = 1'b0;
            after_d     = AfterNone;
            resp_len_d  = 3'd1;
            cnt_d       = '0;
            state_d     = (NCR == 0) ? StResp : StNcrGap;
            r1          = {5'b0, 1'b1, 1'b0, idle};
            case (cmd_idx_q)
              6'd0: begin
                r1           = 8'h01;
                card_ready_d = 1'b0;
                polls_d      = '0;
              end
              6'd8: begin
                r1         = {7'b0, idle};
                resp_len_d = 3'd5;
              end
              6'd41: begin
                if (app_q) begin
                  if (polls_q < 8'(INIT_POLLS)) begin
                    r1      = 8'h01;
                    polls_d = polls_q + 8'd1;
                  end else begin
                    r1           = 8'h00;
                    card_ready_d = 1'b1;
                  end
                end
              end
              6'd55: begin
                r1    = {7'b0, idle};
                app_d = 1'b1;
              end
              6'd58: begin
                r1         = {7'b0, idle};
                resp_len_d = 3'd5;
              end
              6'd17, 6'd24: begin
                if (idle) begin
                  r1 = 8'h05;
                end else begin
                  r1      = 8'h00;
                  after_d = (cmd_idx_q == 6'd17) ? AfterRead : AfterWrite;
                end
              end
              default: ;
            endcase
            resp_d = {r1, 32'hFFFF_FFFF};
            if (cmd_idx_q == 6'd8)  resp_d[31:0] = {24'h000001, arg_q[7:0]};
            if (cmd_idx_q == 6'd58) resp_d[31:0] = 32'hC0FF_8000;
          end
        end
      end
      StNcrGap: begin
        if (byte_done) begin
          if (cnt_q == 10'(NCR - 1)) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StResp: begin
        tx_next = resp_q[39:32];
        if (byte_done) begin
          resp_d = {resp_q[31:0], 8'hFF};
          if (cnt_q[2:0] == resp_len_q - 3'd1) begin
            cnt_d = '0;
            case (after_q)
              AfterRead:  state_d = StRdGap;
              AfterWrite: state_d = StWrToken;
              default:    state_d = StWaitCmd;
            endcase
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StRdGap: begin
        tx_next = (cnt_q == 10'(READ_GAP)) ? 8'hFE : 8'hFF;
        if (byte_done) begin
          if (cnt_q == 10'(READ_GAP)) begin
            cnt_d      = '0;
            mem_addr_d = {arg_q, 9'd0};
            state_d    = StRdData;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StRdData: begin
        // Slots 512 and 513 carry the dummy CRC.
        tx_next = (cnt_q < 10'd512) ? mem_rdata : 8'hFF;
        if (byte_done) begin
          if (cnt_q == 10'd513) begin
            state_d = StWaitCmd;
          end else begin
            cnt_d      = cnt_q + 10'd1;
            mem_addr_d = {arg_q, cnt_q[8:0] + 9'd1};
          end
        end
      end
      StWrToken: begin
        if (byte_done) begin
          if (rx_byte == 8'hFE) begin
            cnt_d   = '0;
            state_d = StWrData;
          end else if (rx_byte != 8'hFF) begin
            state_d = StWaitCmd;
          end
        end
      end
      StWrData: begin
        if (byte_done) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = rx_byte;
          mem_addr_d  = {arg_q, cnt_q[8:0]};
          if (cnt_q == 10'd511) begin
            cnt_d   = '0;
            state_d = StWrCrc;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StWrCrc: begin
        if (byte_done) begin
          if (cnt_q == 10'd1) begin
            cnt_d   = '0;
            state_d = StWrResp;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StWrResp: begin
        tx_next = 8'h05;
        if (byte_done) begin
          cnt_d   = '0;
          state_d = (BUSY_BYTES == 0) ? StWaitCmd : StBusy;
        end
      end
      StBusy: begin
        tx_next = 8'h00;
        if (byte_done) begin
          if (cnt_q == 10'(BUSY_BYTES - 1)) begin
            state_d = StWaitCmd;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = StWaitCmd;
    endcase

    if (!cs_low) begin
      state_d = StWaitCmd;
      cnt_d   = '0;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign card_ready = card_ready_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;

endmodule
